// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the push-button / slide-switch debouncer.
// Holds the board defaults and the counter-width helper used by each channel.
package key_debounce_pkg;

  localparam int DEBOUNCE_STABLE_CNT_50MHZ_10MS = 500000;
  localparam int DEBOUNCE_N_BUTTONS             = 4;

  // STABLE: synchronized input agrees with the accepted level; PENDING: it differs
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

  // Ceiling log2 with a floor of 1, so a 1-cycle debounce still gets a 1-bit counter
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: two-flop synchronizer, stability counter, accepted level,
// and registered one-cycle rise/fall pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CNT = DEBOUNCE_STABLE_CNT_50MHZ_10MS,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_rise,
  output logic key_fall
);

  localparam int              CNT_W    = clog2_min1(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             w_s;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  deb_state_t       w_state;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_level_next;
  logic             w_rise_next;
  logic             w_fall_next;

  // Inversion happens before the synchronizer so "pressed" is always 1 downstream
  assign w_s = key_in ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= w_s;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  // Any return to the accepted level drops the count to zero: no partial credit
  always_comb begin
    w_state      = (r_sync2 == r_level) ? ST_STABLE : ST_PENDING;
    w_cnt_next   = '0;
    w_level_next = r_level;
    w_rise_next  = 1'b0;
    w_fall_next  = 1'b0;
    case (w_state)
      ST_STABLE: begin
        w_cnt_next = '0;
      end
      ST_PENDING: begin
        if (r_cnt == CNT_LAST) begin
          w_level_next = r_sync2;
          w_rise_next  = r_sync2;
          w_fall_next  = ~r_sync2;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_next = '0;
      end
    endcase
  end

  assign key_level = r_level;
  assign key_rise  = r_rise;
  assign key_fall  = r_fall;

endmodule

// File: rtl/key_debounce.sv
// N-channel debouncer placed directly behind the board pins; channels are
// fully independent copies of key_debounce_ch.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N          = DEBOUNCE_N_BUTTONS,
  parameter int STABLE_CNT = DEBOUNCE_STABLE_CNT_50MHZ_10MS,
  parameter int ACTIVE_LOW = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_rise,
  output logic [N-1:0] key_fall
);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in[gi]),
      .key_level (key_level[gi]),
      .key_rise  (key_rise[gi]),
      .key_fall  (key_fall[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: main instance (STABLE_CNT=4), an active-low
// instance and a STABLE_CNT=1 instance share clk and rst.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] k0, kal, ks1;
  logic [3:0] lv0, rs0, fl0;
  logic [3:0] lva, rsa, fla;
  logic [3:0] lv1, rs1, fl1;

  int n_checks;
  int n_err;

  key_debounce #(.N(4), .STABLE_CNT(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .key_in(k0),
    .key_level(lv0), .key_rise(rs0), .key_fall(fl0)
  );

  key_debounce #(.N(4), .STABLE_CNT(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .key_in(kal),
    .key_level(lva), .key_rise(rsa), .key_fall(fla)
  );

  key_debounce #(.N(4), .STABLE_CNT(1), .ACTIVE_LOW(0)) dut_s1 (
    .clk(clk), .rst(rst), .key_in(ks1),
    .key_level(lv1), .key_rise(rs1), .key_fall(fl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  bit bseq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    k0  = 4'b1111;
    kal = 4'b1111;
    ks1 = 4'b0000;

    // Reset held with inputs active: everything stays 0
    repeat (3) begin
      tick();
      chk("rst_level", lv0, 4'b0000);
      chk("rst_rise",  rs0, 4'b0000);
      chk("rst_fall",  fl0, 4'b0000);
    end
    rst = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("rel_wait_level", lv0, 4'b0000);
      chk("rel_wait_rise",  rs0, 4'b0000);
    end
    tick();
    chk("rel_level", lv0, 4'b1111);
    chk("rel_rise",  rs0, 4'b1111);
    chk("rel_fall",  fl0, 4'b0000);
    tick();
    chk("rel_rise_end", rs0, 4'b0000);
    chk("rel_level_hold", lv0, 4'b1111);
    chk("al_idle_level", lva, 4'b0000);
    chk("s1_idle_level", lv1, 4'b0000);

    // Release all channels together
    k0 = 4'b0000;
    repeat (5) tick();
    chk("all_off_wait_level", lv0, 4'b1111);
    chk("all_off_wait_fall",  fl0, 4'b0000);
    tick();
    chk("all_off_level", lv0, 4'b0000);
    chk("all_off_fall",  fl0, 4'b1111);
    tick();
    chk("all_off_fall_end", fl0, 4'b0000);

    // Clean press and release on ch0
    k0 = 4'b0001;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("press_wait_rise",  rs0, 4'b0000);
      chk("press_wait_level", lv0, 4'b0000);
    end
    tick();
    chk("press_level", lv0, 4'b0001);
    chk("press_rise",  rs0, 4'b0001);
    chk("press_fall",  fl0, 4'b0000);
    tick();
    chk("press_rise_end", rs0, 4'b0000);
    chk("press_level_hold", lv0, 4'b0001);
    k0 = 4'b0000;
    repeat (5) tick();
    chk("release_wait_fall", fl0, 4'b0000);
    tick();
    chk("release_fall",  fl0, 4'b0001);
    chk("release_level", lv0, 4'b0000);
    chk("release_rise",  rs0, 4'b0000);
    tick();
    chk("release_fall_end", fl0, 4'b0000);

    // Bounce on ch1, then hold 1
    for (int i = 0; i < 7; i++) begin
      k0[1] = bseq[i];
      tick();
      chk("bounce_rise",  rs0, 4'b0000);
      chk("bounce_level", lv0, 4'b0000);
    end
    k0[1] = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("bounce_hold_rise",  rs0, 4'b0000);
      chk("bounce_hold_level", lv0, 4'b0000);
    end
    tick();
    chk("bounce_rise_final", rs0, 4'b0010);
    chk("bounce_level_final", lv0, 4'b0010);
    tick();
    chk("bounce_rise_end", rs0, 4'b0000);

    // Three-cycle glitch on ch2 is rejected
    k0[2] = 1'b1;
    repeat (3) tick();
    k0[2] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("glitch_level", lv0, 4'b0010);
      chk("glitch_rise",  rs0, 4'b0000);
      chk("glitch_fall",  fl0, 4'b0000);
    end

    // Reset in the middle of ch3's count
    k0[3] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_level", lv0, 4'b0000);
    tick();
    chk("midrst_rise", rs0, 4'b0000);
    rst = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("midrst_wait_rise",  rs0, 4'b0000);
      chk("midrst_wait_level", lv0, 4'b0000);
    end
    tick();
    chk("midrst_rise_after", rs0, 4'b1010);
    chk("midrst_level_after", lv0, 4'b1010);
    tick();
    chk("midrst_rise_end", rs0, 4'b0000);

    // Active-low instance: idle high reads 0, pulling ch0 low is a press
    chk("al_idle_level2", lva, 4'b0000);
    kal[0] = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk("al_wait_rise",  rsa, 4'b0000);
      chk("al_wait_level", lva, 4'b0000);
    end
    tick();
    chk("al_rise",  rsa, 4'b0001);
    chk("al_level", lva, 4'b0001);
    chk("al_fall",  fla, 4'b0000);
    tick();
    chk("al_rise_end", rsa, 4'b0000);

    // STABLE_CNT=1: level follows at edge 2
    ks1 = 4'b0001;
    tick();
    tick();
    chk("s1_edge1_level", lv1, 4'b0000);
    tick();
    chk("s1_edge2_level", lv1, 4'b0001);
    chk("s1_edge2_rise",  rs1, 4'b0001);
    tick();
    chk("s1_rise_end", rs1, 4'b0000);
    ks1 = 4'b0000;
    tick();
    tick();
    chk("s1_off_edge1_level", lv1, 4'b0001);
    tick();
    chk("s1_off_level", lv1, 4'b0000);
    chk("s1_off_fall",  fl1, 4'b0001);

    // Reset acts without waiting for a clock edge
    @(posedge clk);
    #2;
    chk("async_pre_level", lv0, 4'b1010);
    rst = 1'b1;
    #1;
    chk("async_level", lv0, 4'b0000);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
